// File: rtl/dice_roll_pkg.sv
// Shared types and default parameters for the dice roll capture stage.
package dice_roll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int WIDTH_DEF       = 8;
  localparam int RANGE_DEF       = 6;
  localparam int SPIN_CYCLES_DEF = 16;

endpackage

// File: rtl/roll_sync_edge.sv
// Two-flop synchroniser for an asynchronous button plus a third flop that
// turns the synchronised rising edge into a single-cycle pulse.
module roll_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic sync3_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
    end else begin
      sync1_reg <= async_in;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  assign pulse = sync2_reg & ~sync3_reg;

endmodule

// File: rtl/dice_roll_capture.sv
// Spins a display value on a roll request, captures the random byte, and
// reduces it to 1..RANGE by repeated subtraction before a valid/ack handoff.
module dice_roll_capture
  import dice_roll_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int RANGE       = RANGE_DEF,
  parameter int SPIN_CYCLES = SPIN_CYCLES_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Rand_In,
  input  logic             Roll,
  input  logic             Ack,
  output logic             Busy,
  output logic             Valid,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Spin_Val
);

  localparam logic [WIDTH-1:0] RANGE_W   = WIDTH'(RANGE);
  localparam logic [15:0]      SPIN_LAST = 16'(SPIN_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [15:0]      cnt_reg, cnt_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [WIDTH-1:0] spin_reg, spin_next;
  logic             roll_pulse;

  roll_sync_edge u_roll_sync (
    .clk      (Clk),
    .rst_n    (Rst),
    .async_in (Roll),
    .pulse    (roll_pulse)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      work_reg   <= '0;
      result_reg <= '0;
      spin_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      work_reg   <= work_next;
      result_reg <= result_next;
      spin_reg   <= spin_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    work_next   = work_reg;
    result_next = result_reg;
    spin_next   = spin_reg;
    unique case (state_reg)
      IDLE: begin
        if (roll_pulse) begin
          state_next = SPIN;
          cnt_next   = '0;
        end
      end
      SPIN: begin
        spin_next = Rand_In;
        cnt_next  = cnt_reg + 16'd1;
        if (cnt_reg == SPIN_LAST) begin
          work_next  = Rand_In;
          state_next = REDUCE;
        end
      end
      REDUCE: begin
        if (work_reg >= RANGE_W) begin
          work_next = work_reg - RANGE_W;
        end else begin
          result_next = work_reg + WIDTH'(1);
          state_next  = DONE;
        end
      end
      DONE: begin
        // A fresh roll takes priority over a simultaneous acknowledge.
        if (roll_pulse) begin
          state_next = SPIN;
          cnt_next   = '0;
        end else if (Ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy     = (state_reg == SPIN) || (state_reg == REDUCE);
  assign Valid    = (state_reg == DONE);
  assign Result   = result_reg;
  assign Spin_Val = spin_reg;

endmodule

// File: tb/tb_dice_roll_capture.sv
// Directed bench for dice_roll_capture with hand-computed latencies/results.
module tb_dice_roll_capture;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] Rand_In;
  logic       Roll;
  logic       Ack;
  logic       Busy;
  logic       Valid;
  logic [7:0] Result;
  logic [7:0] Spin_Val;

  int tests  = 0;
  int failed = 0;

  dice_roll_capture dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Rand_In  (Rand_In),
    .Roll     (Roll),
    .Ack      (Ack),
    .Busy     (Busy),
    .Valid    (Valid),
    .Result   (Result),
    .Spin_Val (Spin_Val)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts edges after the roll rise until Valid, dropping Roll at edge rel.
  task automatic wait_valid(input int lat0, input int rel, output int lat);
    lat = lat0;
    while (Valid !== 1'b1 && lat < 1000) begin
      tick();
      lat++;
      if (lat == rel) Roll = 1'b0;
    end
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
  endtask

  logic [7:0] vals    [4] = '{8'd0, 8'd255, 8'd5, 8'd6};
  logic [7:0] exp_res [4] = '{8'd1, 8'd4, 8'd6, 8'd1};
  int         exp_lat [4] = '{20, 62, 20, 21};

  initial begin
    int lat;
    int busy_rises;
    int valid_rises;
    logic prev_busy;
    logic prev_valid;
    logic [7:0] exp_spin;

    Rst = 1'b0; Roll = 1'b0; Ack = 1'b0; Rand_In = 8'd0;
    #2;
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_valid", 32'(Valid), 32'd0);
    check("reset_result", 32'(Result), 32'd0);
    check("reset_spin", 32'(Spin_Val), 32'd0);
    repeat (2) tick();
    Rst = 1'b1;
    repeat (2) tick();

    // Nominal roll with constant 200: 3 + 16 + 34 = 53
    Rand_In = 8'd200;
    Roll = 1'b1;
    tick(); tick();
    check("nom_busy_c2", 32'(Busy), 32'd0);
    tick();
    check("nom_busy_c3", 32'(Busy), 32'd1);
    tick();
    check("nom_spin_c4", 32'(Spin_Val), 32'd200);
    wait_valid(4, 5, lat);
    check("nom_latency", 32'(lat), 32'd53);
    check("nom_result", 32'(Result), 32'd3);
    $display("[TB] roll 200 -> result %0d after %0d cycles", Result, lat);

    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid_result", {23'd0, Valid, Result}, {23'd0, 1'b1, 8'd3});
    end
    do_ack();
    check("ack_valid", 32'(Valid), 32'd0);
    check("ack_busy", 32'(Busy), 32'd0);
    check("ack_result", 32'(Result), 32'd3);
    tick();
    check("ack_idle", {30'd0, Busy, Valid}, 32'd0);
    $display("[TB] ack -> valid %0d busy %0d result %0d", Valid, Busy, Result);

    for (int i = 0; i < 4; i++) begin
      Rand_In = vals[i];
      Roll = 1'b1;
      wait_valid(0, 5, lat);
      check("bound_latency", 32'(lat), 32'(exp_lat[i]));
      check("bound_result", 32'(Result), 32'(exp_res[i]));
      $display("[TB] roll %0d -> result %0d after %0d cycles", vals[i], Result, lat);
      do_ack();
      check("bound_ack", 32'(Valid), 32'd0);
    end

    // Second roll pressed during REDUCE must be ignored
    Rand_In = 8'd200;
    Roll = 1'b1;
    repeat (5) tick();
    Roll = 1'b0;
    repeat (20) tick();
    check("busy_in_reduce", 32'(Busy), 32'd1);
    Roll = 1'b1;
    repeat (5) tick();
    Roll = 1'b0;
    wait_valid(30, 0, lat);
    check("busy_roll_latency", 32'(lat), 32'd53);
    check("busy_roll_result", 32'(Result), 32'd3);
    do_ack();
    valid_rises = 0;
    busy_rises = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (Valid === 1'b1) valid_rises++;
      if (Busy === 1'b1) busy_rises++;
    end
    check("no_queued_valid", 32'(valid_rises), 32'd0);
    check("no_queued_busy", 32'(busy_rises), 32'd0);
    $display("[TB] roll during reduce -> extra busy cycles %0d", busy_rises);

    // Roll and Ack in the same DONE cycle: roll wins
    Rand_In = 8'd13;
    Roll = 1'b1;
    wait_valid(0, 5, lat);
    check("pre_done_latency", 32'(lat), 32'd22);
    check("pre_done_result", 32'(Result), 32'd2);
    Rand_In = 8'd35;
    Roll = 1'b1;
    tick(); tick();
    check("done_still_valid", 32'(Valid), 32'd1);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    check("roll_ack_valid", 32'(Valid), 32'd0);
    check("roll_ack_busy", 32'(Busy), 32'd1);
    wait_valid(3, 5, lat);
    check("roll_ack_latency", 32'(lat), 32'd25);
    check("roll_ack_result", 32'(Result), 32'd6);
    $display("[TB] roll+ack in done -> result %0d after %0d cycles", Result, lat);
    do_ack();

    // Held roll gives exactly one sequence
    Rand_In = 8'd6;
    Roll = 1'b1;
    busy_rises = 0;
    valid_rises = 0;
    prev_busy = 1'b0;
    prev_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (Busy === 1'b1 && prev_busy === 1'b0) busy_rises++;
      if (Valid === 1'b1 && prev_valid === 1'b0) valid_rises++;
      prev_busy = Busy;
      prev_valid = Valid;
    end
    check("held_busy_rises", 32'(busy_rises), 32'd1);
    check("held_valid_rises", 32'(valid_rises), 32'd1);
    check("held_result", 32'(Result), 32'd1);
    $display("[TB] held roll -> %0d sequence(s), result %0d", busy_rises, Result);
    Roll = 1'b0;
    repeat (4) tick();
    do_ack();
    check("held_ack", 32'(Valid), 32'd0);

    // Spin_Val follows a ramp only during SPIN; captured 19 -> Result 2
    for (int c = 1; c <= 23; c++) begin
      Rand_In = 8'(c);
      if (c == 1) Roll = 1'b1;
      if (c == 5) Roll = 1'b0;
      tick();
      if (c <= 3) exp_spin = 8'd6;
      else if (c <= 19) exp_spin = 8'(c);
      else exp_spin = 8'd19;
      check("ramp_spin", 32'(Spin_Val), 32'(exp_spin));
      check("ramp_valid", 32'(Valid), (c >= 23) ? 32'd1 : 32'd0);
    end
    check("ramp_result", 32'(Result), 32'd2);
    $display("[TB] ramp roll -> spin %0d result %0d", Spin_Val, Result);
    do_ack();

    // Reset mid-SPIN aborts the roll
    Rand_In = 8'hA5;
    Roll = 1'b1;
    repeat (10) tick();
    check("pre_reset_busy", 32'(Busy), 32'd1);
    #2;
    Rst = 1'b0;
    #1;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_valid", 32'(Valid), 32'd0);
    check("abort_result", 32'(Result), 32'd0);
    check("abort_spin", 32'(Spin_Val), 32'd0);
    Roll = 1'b0;
    #2;
    Rst = 1'b1;
    valid_rises = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (Valid === 1'b1 || Busy === 1'b1) valid_rises++;
    end
    check("abort_no_valid", 32'(valid_rises), 32'd0);
    $display("[TB] reset mid-spin -> active cycles after release %0d", valid_rises);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dice_roll_capture.md
Name: dice_roll_capture

Overview:
- Consumer stage directly downstream of the 8-bit LFSR pseudo-random generator in the arcade design.
- On a player "roll" request, shows a spinning value for a fixed number of cycles.
- Then freezes the current random byte and reduces it into the range 1..RANGE by sequential repeated subtraction.
- Presents the result with a valid/ack handshake to the game/score logic and display.

Parameters:
- WIDTH, 8, width of random input, working register and Result.
- RANGE, 6, number of faces; legal 2..255.
- SPIN_CYCLES, 16, cycles spent in SPIN before capture; legal 1..65535.

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Rst  input  1  asynchronous active-low reset.
- Rand_In  input  WIDTH  free-running random value from the LFSR stage.
- Roll  input  1  asynchronous player button, active high, level.
- Ack  input  1  consumer has taken Result; sampled only while Valid=1.
- Busy  output  1  high in SPIN and REDUCE.
- Valid  output  1  Result is stable and meaningful.
- Result  output  WIDTH  reduced roll value, 1..RANGE.
- Spin_Val  output  WIDTH  animation value for the display.

Behaviour:
- Reset (Rst=0, asynchronous), all values 0:
  - State=IDLE; Busy=0, Valid=0, Result=0, Spin_Val=0.
  - Sync flops, spin counter and Work register also 0.
- Roll is synchronised by 2 flops, plus a third flop for edge detection.
  - roll_pulse = sync2 & ~sync3: a one-cycle pulse 3 cycles after the Roll rise.
  - A held Roll produces exactly one pulse.
- IDLE:
  - Spin_Val holds its last value.
  - roll_pulse -> SPIN; spin counter cleared.
- SPIN:
  - Busy=1.
  - Each cycle, Spin_Val <= Rand_In and the counter increments.
  - When counter == SPIN_CYCLES-1: Work <= Rand_In (capture), then -> REDUCE.
- REDUCE:
  - Busy=1.
  - One operation per cycle:
    - If Work >= RANGE: Work <= Work - RANGE.
    - Else: Result <= Work + 1, Valid <= 1, -> DONE.
  - Cycles spent in REDUCE = floor(captured/RANGE) + 1; worst case 256 cycles for RANGE=1 (illegal), 128 for RANGE=2.
  - Arithmetic is unsigned WIDTH bits; Work + 1 never overflows because Work < RANGE <= 255.
- DONE:
  - Busy=0; Valid=1; Result held.
  - Ack=1 -> Valid <= 0, -> IDLE; Result keeps its value.
  - roll_pulse in DONE (with or without Ack) -> Valid <= 0, -> SPIN. The roll wins.
- roll_pulse during SPIN or REDUCE is ignored; no queuing.
- Ack is ignored when Valid=0.
- Latency from Roll rise to Valid=1: 3 (sync + edge) + SPIN_CYCLES + floor(captured/RANGE) + 1 cycles.
- Captured value 0 gives Result=1; captured 255 with RANGE=6 gives Result=4.
- Reset asserted mid-SPIN or mid-REDUCE aborts immediately to the reset state. No Valid is produced for the aborted roll.
- Rand_In is only sampled in SPIN; its value in other states is don't-care.

Decomposition:
- Package dice_roll_pkg:
  - state typedef {IDLE, SPIN, REDUCE, DONE}, 2-bit encoding.
  - Default constants WIDTH_DEF=8, RANGE_DEF=6, SPIN_CYCLES_DEF=16.
- One sub-module, roll_sync_edge:
  - 3-flop synchroniser plus rising-edge pulse, with its own async active-low reset.
  - Reused for other arcade buttons.
- FSM, counter and subtractor stay in dice_roll_capture.

Test Plan:
- Reset: assert Rst=0 mid-SPIN with Rand_In=8'hA5 -> immediately Busy=0, Valid=0, Result=0, Spin_Val=0; no Valid after release.
- Nominal (RANGE=6, SPIN_CYCLES=16, Rand_In constant 200): Roll rise at cycle 0 -> Busy high at cycle 3, Spin_Val=200, Valid high at cycle 3+16+34=53, Result=3.
- Boundaries (RANGE=6): captured 0 -> Result=1 after 1 REDUCE cycle; captured 255 -> Result=4 after 43 REDUCE cycles; captured 5 -> Result=6; captured 6 -> Result=1.
- Handshake: Valid held for 10 cycles with Ack=0, Result stable; Ack=1 for one cycle -> Valid=0 next cycle, state IDLE, Result unchanged.
- Roll while Busy: second Roll pulse during REDUCE -> ignored, exactly one Valid. Roll and Ack in the same DONE cycle -> Valid=0, Busy=1 next cycle, new Result after full latency.
- Held Roll: Roll held high 100 cycles -> exactly one roll sequence. Glitch-free Spin_Val tracks a changing Rand_In sequence (e.g. 1,2,3,...) during SPIN only.
